// File: rtl/tmr_regfile_scrub_pkg.sv
// Shared constants for the triple-redundant register file: scrubber state
// encoding and the correction counter width.
package tmr_pkg;

    localparam int CNT_W = 16;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT      = 2'd1,
        READ      = 2'd2,
        WRITEBACK = 2'd3
    } scrub_state_t;

endpackage

// File: rtl/tmr_regfile_scrub_vote3.sv
// Bitwise 2-of-3 majority over three register copies, plus a flag raised
// whenever any bit of the copies disagrees.
module tmr_vote3 #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] c,
    output logic [WIDTH-1:0] voted,
    output logic             mismatch
);

    assign voted    = (a & b) | (a & c) | (b & c);
    assign mismatch = |((a ^ b) | (a ^ c));

endmodule

// File: rtl/tmr_regfile_scrub.sv
// Triple-redundant register file with voted reads, a background scrubber that
// rewrites disagreeing copies, and a single-copy fault-injection port.
module tmr_regfile_scrub
    import tmr_pkg::*;
#(
    parameter int NREG      = 32,
    parameter int WIDTH     = 32,
    parameter int AW        = $clog2(NREG),
    parameter int SCRUB_GAP = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             we3,
    input  logic [AW-1:0]    wa3,
    input  logic [WIDTH-1:0] wd3,
    input  logic [AW-1:0]    ra1,
    input  logic [AW-1:0]    ra2,
    output logic [WIDTH-1:0] rd1,
    output logic [WIDTH-1:0] rd2,
    input  logic             scrub_en,
    input  logic             inj_en,
    input  logic [1:0]       inj_copy,
    input  logic [AW-1:0]    inj_addr,
    input  logic [WIDTH-1:0] inj_mask,
    input  logic             clr_err,
    output logic             scrub_busy,
    output logic [AW-1:0]    scrub_addr,
    output logic [CNT_W-1:0] corr_cnt,
    output logic             err_sticky
);

    localparam int GW = (SCRUB_GAP > 1) ? $clog2(SCRUB_GAP) : 1;
    localparam logic [GW-1:0] GAP_LOAD = GW'(SCRUB_GAP - 1);

    logic [WIDTH-1:0] c0 [NREG];
    logic [WIDTH-1:0] c1 [NREG];
    logic [WIDTH-1:0] c2 [NREG];

    scrub_state_t     state;
    logic [GW-1:0]    gap_cnt;
    logic [WIDTH-1:0] v1, v2, scrub_vote;
    logic             unused_mis1, unused_mis2, scrub_mismatch;
    logic             cpu_we, scrub_wr;
    logic [AW-1:0]    next_addr;
    logic [WIDTH-1:0] inj_cur, inj_val;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    tmr_vote3 #(.WIDTH(WIDTH)) u_vote_rd1 (
        .a(c0[ra1]), .b(c1[ra1]), .c(c2[ra1]), .voted(v1), .mismatch(unused_mis1)
    );
    tmr_vote3 #(.WIDTH(WIDTH)) u_vote_rd2 (
        .a(c0[ra2]), .b(c1[ra2]), .c(c2[ra2]), .voted(v2), .mismatch(unused_mis2)
    );
    tmr_vote3 #(.WIDTH(WIDTH)) u_vote_scrub (
        .a(c0[scrub_addr]), .b(c1[scrub_addr]), .c(c2[scrub_addr]),
        .voted(scrub_vote), .mismatch(scrub_mismatch)
    );

    assign rd1        = (ra1 != '0) ? v1 : '0;
    assign rd2        = (ra2 != '0) ? v2 : '0;
    assign cpu_we     = we3 && (wa3 != '0);
    assign scrub_wr   = scrub_en && (state == WRITEBACK) && !cpu_we && scrub_mismatch;
    assign next_addr  = (scrub_addr == AW'(NREG - 1)) ? AW'(1) : scrub_addr + AW'(1);
    assign scrub_busy = (state == READ) || (state == WRITEBACK);

    // Injection corrupts whatever that copy would otherwise hold after this edge.
    always_comb begin
        inj_cur = '0;
        case (inj_copy)
            2'd0:    inj_cur = c0[inj_addr];
            2'd1:    inj_cur = c1[inj_addr];
            2'd2:    inj_cur = c2[inj_addr];
            default: ;
        endcase
        if (cpu_we && (wa3 == inj_addr))
            inj_cur = wd3;
        else if (scrub_wr && (scrub_addr == inj_addr))
            inj_cur = scrub_vote;
        inj_val = inj_cur ^ inj_mask;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NREG; i++) begin
                c0[i] <= '0;
                c1[i] <= '0;
                c2[i] <= '0;
            end
        end else begin
            if (cpu_we) begin
                c0[wa3] <= wd3;
                c1[wa3] <= wd3;
                c2[wa3] <= wd3;
            end else if (scrub_wr) begin
                c0[scrub_addr] <= scrub_vote;
                c1[scrub_addr] <= scrub_vote;
                c2[scrub_addr] <= scrub_vote;
            end
            if (inj_en) begin
                case (inj_copy)
                    2'd0:    c0[inj_addr] <= inj_val;
                    2'd1:    c1[inj_addr] <= inj_val;
                    2'd2:    c2[inj_addr] <= inj_val;
                    default: ;
                endcase
            end
        end
    end

    // A CPU write in WRITEBACK stalls the scrubber; the re-vote then decides.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            scrub_addr <= AW'(1);
            gap_cnt    <= '0;
            corr_cnt   <= '0;
            err_sticky <= 1'b0;
        end else begin
            if (clr_err)
                err_sticky <= 1'b0;
            if (!scrub_en) begin
                state <= IDLE;
            end else begin
                case (state)
                    IDLE: begin
                        state   <= WAIT;
                        gap_cnt <= GAP_LOAD;
                    end
                    WAIT: begin
                        if (gap_cnt == '0)
                            state <= READ;
                        else
                            gap_cnt <= gap_cnt - 1'b1;
                    end
                    READ: begin
                        if (scrub_mismatch) begin
                            err_sticky <= 1'b1;
                            state      <= WRITEBACK;
                        end else begin
                            scrub_addr <= next_addr;
                            gap_cnt    <= GAP_LOAD;
                            state      <= WAIT;
                        end
                    end
                    WRITEBACK: begin
                        if (!cpu_we) begin
                            if (scrub_mismatch)
                                corr_cnt <= sat_inc(corr_cnt);
                            scrub_addr <= next_addr;
                            gap_cnt    <= GAP_LOAD;
                            state      <= WAIT;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_tmr_regfile_scrub.sv
// Directed bench for the triple-redundant register file and its scrubber.
module tb_tmr_regfile_scrub;
    import tmr_pkg::*;

    localparam int NREG = 32;
    localparam int WIDTH = 32;
    localparam int AW = 5;
    localparam int SCRUB_GAP = 2;

    logic             clk = 1'b0;
    logic             reset;
    logic             we3;
    logic [AW-1:0]    wa3;
    logic [WIDTH-1:0] wd3;
    logic [AW-1:0]    ra1, ra2;
    logic [WIDTH-1:0] rd1, rd2;
    logic             scrub_en, inj_en, clr_err;
    logic [1:0]       inj_copy;
    logic [AW-1:0]    inj_addr;
    logic [WIDTH-1:0] inj_mask;
    logic             scrub_busy;
    logic [AW-1:0]    scrub_addr;
    logic [15:0]      corr_cnt;
    logic             err_sticky;

    int n_cmp = 0;
    int n_mis = 0;

    tmr_regfile_scrub #(
        .NREG(NREG), .WIDTH(WIDTH), .AW(AW), .SCRUB_GAP(SCRUB_GAP)
    ) dut (
        .clk(clk), .reset(reset),
        .we3(we3), .wa3(wa3), .wd3(wd3),
        .ra1(ra1), .ra2(ra2), .rd1(rd1), .rd2(rd2),
        .scrub_en(scrub_en),
        .inj_en(inj_en), .inj_copy(inj_copy), .inj_addr(inj_addr), .inj_mask(inj_mask),
        .clr_err(clr_err),
        .scrub_busy(scrub_busy), .scrub_addr(scrub_addr),
        .corr_cnt(corr_cnt), .err_sticky(err_sticky)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic inject(input logic [1:0] cp, input logic [AW-1:0] ad, input logic [WIDTH-1:0] m);
        inj_en = 1'b1; inj_copy = cp; inj_addr = ad; inj_mask = m;
        tick();
        inj_en = 1'b0; inj_copy = 2'd3; inj_mask = '0;
    endtask

    initial begin
        reset = 1'b1; we3 = 1'b0; wa3 = '0; wd3 = '0; ra1 = 5'd5; ra2 = '0;
        scrub_en = 1'b0; inj_en = 1'b0; inj_copy = 2'd3; inj_addr = '0;
        inj_mask = '0; clr_err = 1'b0;
        tick(); tick();
        chk("reset_rd1", rd1, 32'h0);
        chk("reset_addr", 32'(scrub_addr), 32'd1);
        chk("reset_corr", 32'(corr_cnt), 32'd0);
        chk("reset_err", 32'(err_sticky), 32'd0);
        chk("reset_busy", 32'(scrub_busy), 32'd0);
        reset = 1'b0;
        tick();

        // CPU writes: reg 5, then an attempted write to reg 0
        we3 = 1'b1; wa3 = 5'd5; wd3 = 32'hDEADBEEF;
        tick();
        chk("write_rd1", rd1, 32'hDEADBEEF);
        wa3 = 5'd0; wd3 = 32'h12345678;
        tick();
        we3 = 1'b0;
        #1;
        chk("reg0_rd2", rd2, 32'h0);

        // Single-copy corruption masked by the vote, scrubber off
        inject(2'd1, 5'd5, 32'h0000FFFF);
        chk("inj_rd1", rd1, 32'hDEADBEEF);
        chk("inj_c1", dut.c1[5], 32'hDEAD4110);
        chk("inj_corr", 32'(corr_cnt), 32'd0);
        chk("inj_err", 32'(err_sticky), 32'd0);

        // Scrubber corrects reg 5
        scrub_en = 1'b1;
        for (int i = 0; i < 94 && corr_cnt != 16'd1; i++) tick();
        chk("scrub5_corr", 32'(corr_cnt), 32'd1);
        chk("scrub5_err", 32'(err_sticky), 32'd1);
        chk("scrub5_c0", dut.c0[5], 32'hDEADBEEF);
        chk("scrub5_c1", dut.c1[5], 32'hDEADBEEF);
        chk("scrub5_c2", dut.c2[5], 32'hDEADBEEF);
        chk("scrub5_addr", 32'(scrub_addr), 32'd6);

        // Two copies of reg 7 corrupted alike: the corrupted value wins the vote
        inject(2'd0, 5'd7, 32'h1);
        inject(2'd1, 5'd7, 32'h1);
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        chk("clr_err", 32'(err_sticky), 32'd0);
        for (int i = 0; i < 20 && corr_cnt != 16'd2; i++) tick();
        chk("scrub7_corr", 32'(corr_cnt), 32'd2);
        chk("scrub7_err", 32'(err_sticky), 32'd1);
        chk("scrub7_c2", dut.c2[7], 32'h1);
        chk("scrub7_addr", 32'(scrub_addr), 32'd8);

        // CPU write to reg 9 while the scrubber sits in WRITEBACK on it
        inject(2'd2, 5'd9, 32'h000000F0);
        for (int i = 0; i < 20 && dut.state != WRITEBACK; i++) tick();
        chk("wb9_state", 32'(dut.state), 32'(WRITEBACK));
        chk("wb9_addr", 32'(scrub_addr), 32'd9);
        we3 = 1'b1; wa3 = 5'd9; wd3 = 32'hCAFE0009;
        tick();
        chk("stall1_state", 32'(dut.state), 32'(WRITEBACK));
        chk("stall1_busy", 32'(scrub_busy), 32'd1);
        tick();
        chk("stall2_state", 32'(dut.state), 32'(WRITEBACK));
        chk("stall2_addr", 32'(scrub_addr), 32'd9);
        we3 = 1'b0;
        tick();
        chk("unstall_addr", 32'(scrub_addr), 32'd10);
        chk("unstall_corr", 32'(corr_cnt), 32'd2);
        chk("unstall_state", 32'(dut.state), 32'(WAIT));
        chk("unstall_c2", dut.c2[9], 32'hCAFE0009);

        // Pointer wrap 31 -> 1
        for (int i = 0; i < 80 && scrub_addr != 5'd31; i++) tick();
        chk("reach31", 32'(scrub_addr), 32'd31);
        for (int i = 0; i < 6 && scrub_addr == 5'd31; i++) tick();
        chk("wrap_addr", 32'(scrub_addr), 32'd1);

        // Counter saturation
        scrub_en = 1'b0;
        tick();
        chk("idle_state", 32'(dut.state), 32'(IDLE));
        force dut.corr_cnt = 16'hFFFE;
        #1;
        release dut.corr_cnt;
        #1;
        chk("preset_corr", 32'(corr_cnt), 32'h0000FFFE);
        inject(2'd0, 5'd12, 32'h1);
        inject(2'd0, 5'd13, 32'h1);
        scrub_en = 1'b1;
        for (int i = 0; i < 60 && corr_cnt != 16'hFFFF; i++) tick();
        chk("sat_first", 32'(corr_cnt), 32'h0000FFFF);
        for (int i = 0; i < 20 && scrub_addr != 5'd14; i++) tick();
        chk("sat_addr", 32'(scrub_addr), 32'd14);
        chk("sat_hold", 32'(corr_cnt), 32'h0000FFFF);
        chk("sat_c0_13", dut.c0[13], 32'h0);

        // Reset asserted in the middle of a writeback
        inject(2'd1, 5'd20, 32'h000000FF);
        for (int i = 0; i < 40 && dut.state != WRITEBACK; i++) tick();
        chk("wb20_addr", 32'(scrub_addr), 32'd20);
        ra1 = 5'd5; ra2 = 5'd9;
        reset = 1'b1;
        #1;
        chk("rst_state", 32'(dut.state), 32'(IDLE));
        chk("rst_addr", 32'(scrub_addr), 32'd1);
        chk("rst_corr", 32'(corr_cnt), 32'd0);
        chk("rst_err", 32'(err_sticky), 32'd0);
        chk("rst_busy", 32'(scrub_busy), 32'd0);
        chk("rst_rd1", rd1, 32'h0);
        chk("rst_rd2", rd2, 32'h0);
        chk("rst_c1_20", dut.c1[20], 32'h0);
        scrub_en = 1'b0;
        tick();
        reset = 1'b0;
        tick();
        chk("post_rst_state", 32'(dut.state), 32'(IDLE));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
